// File: rtl/aes_ks_pkg.sv
// Shared types, round constants and word helpers for the AES-128 inverse key schedule.
package aes_ks_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [127:0]      key_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index 0 is never used: the round-0 key ends the walk rather than producing a new one.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel AES S-boxes applied to one 32-bit word (combinational SubWord).
module aes_subword
    import aes_ks_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Byte 0x00 occupies the top byte, so a lookup lands at bit offset {~b, 3'b000}.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            word_o[i*8 +: 8] = sbox(word_i[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 round keys in reverse order (round 10 -> 0) over a valid/ready stream.
// Build option INVKS_KEY_ZEROIZE_EN clears the key register when the walk completes.
module aes_inv_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int unsigned NR    = 10,
    parameter int unsigned KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);

    generate
        if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
            $error("aes_inv_key_schedule supports only NR=10, KEY_W=128");
        end
    endgenerate

    state_t               state_q, state_d;
    key_t                 key_q, key_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    word_t w0, w1, w2, w3;
    word_t n0, n1, n2, n3;
    word_t sub_out;
    logic  hs;

    assign {w0, w1, w2, w3} = key_q;
    assign hs = valid_q && rk_ready;

    // One inverse expansion step; w3 ^ w2 recovers the previous round's last word.
    assign n3 = w3 ^ w2;
    assign n2 = w2 ^ w1;
    assign n1 = w1 ^ w0;
    assign n0 = w0 ^ sub_out ^ {RCON[round_q], 24'h0};

    aes_subword u_subword (
        .word_i (rot_word(n3)),
        .word_o (sub_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (hs && round_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    key_d   = key_in;
                    round_d = ROUND_W'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    if (round_q != '0) begin
                        key_d   = {n0, n1, n2, n3};
                        round_d = round_q - ROUND_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`ifdef INVKS_KEY_ZEROIZE_EN
                        key_d   = '0;
                        round_d = '0;
`else
                        key_d   = key_q;
`endif
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign rk_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: FIPS-197 vector, backpressure, ignored start, reset, random keys.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [11];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic init_tables();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_m[0] = 8'h00;
        rcon_m[1] = 8'h01;
        for (int r = 2; r <= 10; r++) rcon_m[r] = gf_mul(rcon_m[r-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Reverse the FIPS-197 word recurrence w[i+4] = w[i] ^ temp(w[i+3]) from w[40..43].
    task automatic build_model(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
        for (int i = 39; i >= 0; i--) begin
            t = w[i+3];
            if ((i % 4) == 0)
                t = sub_word_m({t[23:0], t[31:24]}) ^ {rcon_m[(i+4)/4], 24'h0};
            w[i] = w[i+4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge where done shows
    // (or after a reset check), so a follow-on call exercises start-in-done-cycle.
    task automatic run_key(input logic [127:0] k, input int stall_at, input int stall_len,
                           input int poke_at, input int rst_at, input bit rnd_ready,
                           input bit chk_lat);
        int  exp_r = 10;
        int  cyc   = 0;
        int  stalls = stall_len;
        bit  poked = 0;
        bit  rdy;
        build_model(k);
        start = 1'b1; key_in = k; rk_ready = 1'b0;
        @(negedge clk); cyc++;
        start = 1'b0; key_in = ~k;
        while (1) begin
            chk("valid", 128'(rk_valid), 128'(1));
            chk("busy", 128'(busy), 128'(1));
            chk("round", 128'(rk_round), 128'(exp_r));
            chk($sformatf("key_r%0d", exp_r), rk_out, exp_rk[exp_r]);
            got_rk[exp_r] = rk_out;
            if (exp_r == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_out", {rk_out, 4'(rk_round), rk_valid, busy, done}, '0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("rst_nodone", 128'(done), 128'(0));
                end
                return;
            end
            if (exp_r == stall_at && stalls > 0) begin
                rdy = 1'b0;
                stalls--;
            end else begin
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            rk_ready = rdy;
            if (exp_r == poke_at && !poked) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
                poked  = 1;
            end
            @(negedge clk); cyc++;
            start = 1'b0;
            if (rdy) begin
                if (exp_r == 0) break;
                exp_r--;
            end
            if (cyc > 300) begin
                chk("timeout", 128'(0), 128'(1));
                return;
            end
        end
        rk_ready = 1'b0;
        chk("done", 128'(done), 128'(1));
        chk("done_valid", 128'(rk_valid), 128'(0));
        chk("done_busy", 128'(busy), 128'(0));
        chk("done_round", 128'(rk_round), 128'(0));
`ifdef INVKS_KEY_ZEROIZE_EN
        chk("done_key", rk_out, 128'(0));
`else
        chk("done_key", rk_out, exp_rk[0]);
`endif
        if (chk_lat) chk("latency", 128'(cyc), 128'(12));
    endtask

    task automatic idle_after_done();
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'(0));
        chk("idle_valid", 128'(rk_valid), 128'(0));
    endtask

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        init_tables();
        repeat (2) @(negedge clk);
        chk("reset_out", {rk_out, 4'(rk_round), rk_valid, busy, done}, '0);
        rst = 1'b0;
        @(negedge clk);

        run_key(FIPS_K10, -1, 0, -1, -1, 1'b0, 1'b1);
        chk("fips_r9", got_rk[9], FIPS_K9);
        chk("fips_r0", got_rk[0], FIPS_K0);
        idle_after_done();

        run_key(FIPS_K10, 5, 3, -1, -1, 1'b0, 1'b0);
        chk("bp_r0", got_rk[0], FIPS_K0);
        idle_after_done();

        run_key(FIPS_K10, -1, 0, 7, -1, 1'b0, 1'b0);
        idle_after_done();

        run_key(FIPS_K10, -1, 0, -1, 4, 1'b0, 1'b0);
        run_key({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, -1, 1'b0, 1'b1);

        run_key(128'h0, -1, 0, -1, -1, 1'b0, 1'b0);
        // Start in the done cycle must be accepted immediately.
        for (int t = 0; t < 4; t++)
            run_key({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 10),
                    $urandom_range(1, 3), -1, -1, 1'b1, 1'b0);
        idle_after_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
